// File: rtl/rtl_settings_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rtl_settings_pkg
//  Purpose  : Shared Avalon-MM widths and arbiter types for the memory port.
//  Revision : 1.0 - initial release
// ============================================================================
package rtl_settings_pkg;

    localparam int AMM_ADDR_W  = 26;
    localparam int AMM_DATA_W  = 32;
    localparam int AMM_BURST_W = 4;
    localparam int DATA_B_W    = AMM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WR_BURST = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   id;
        logic [AMM_BURST_W-1:0] burstcount;
    } rd_order_t;

    // A burstcount of zero is handled as a single beat.
    function automatic logic [AMM_BURST_W-1:0] eff_burst(input logic [AMM_BURST_W-1:0] bc);
        return (bc == '0) ? {{(AMM_BURST_W-1){1'b0}}, 1'b1} : bc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : arb_order_fifo
//  Purpose  : Show-ahead FIFO recording owner and length of each issued read.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_order_fifo
    import rtl_settings_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      push_i,
    input  rd_order_t push_data_i,
    input  logic      pop_i,
    output rd_order_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    rd_order_t      mem_q [DEPTH];
    rd_order_t      mem_d [DEPTH];
    logic           w_do_push;
    logic           w_do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_push = push_i & (~full_o | pop_i);
    assign w_do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data_i;
            wr_ptr_d                   = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Two-master Avalon-MM command arbiter with in-order read return.
//             Define MEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import rtl_settings_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [1:0]                        m_read_i,
    input  logic [1:0]                        m_write_i,
    input  logic [1:0][AMM_ADDR_W-1:0]        m_address_i,
    input  logic [1:0][AMM_DATA_W-1:0]        m_writedata_i,
    input  logic [1:0][AMM_BURST_W-1:0]       m_burstcount_i,
    input  logic [1:0][DATA_B_W-1:0]          m_byteenable_i,
    output logic [1:0]                        m_waitrequest_o,
    output logic [1:0]                        m_readdatavalid_o,
    output logic [AMM_DATA_W-1:0]             m_readdata_o,
    output logic [AMM_ADDR_W-1:0]             mem_address_o,
    output logic                              mem_read_o,
    output logic                              mem_write_o,
    output logic [AMM_DATA_W-1:0]             mem_writedata_o,
    output logic [AMM_BURST_W-1:0]            mem_burstcount_o,
    output logic [DATA_B_W-1:0]               mem_byteenable_o,
    input  logic                              mem_waitrequest_i,
    input  logic                              mem_readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]             mem_readdata_i,
    output logic                              rsp_err_o
);

    localparam logic [AMM_BURST_W-1:0] c_one = {{(AMM_BURST_W-1){1'b0}}, 1'b1};

    arb_state_t             state_q, state_d;
    logic                   grant_id_q, grant_id_d;
    logic [AMM_BURST_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [AMM_BURST_W-1:0] rd_cnt_q, rd_cnt_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [1:0]             w_req;
    logic                   w_winner;
    logic                   w_rd_req;
    logic                   w_wr_req;
    logic                   w_rd_block;
    logic                   w_push;
    rd_order_t              w_push_data;
    rd_order_t              w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_beat;
    logic                   w_pop;
    logic [AMM_BURST_W-1:0] w_rd_remaining;

    assign w_req = m_read_i | m_write_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign w_winner     = (&w_req) ? ~last_grant_q : ~w_req[0];
    assign last_grant_d = (state_q == IDLE && |w_req) ? w_winner : last_grant_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign w_winner = ~w_req[0];
`endif

    // A master raising both strobes is served as a read.
    assign w_rd_req    = m_read_i[grant_id_q];
    assign w_wr_req    = m_write_i[grant_id_q] & ~m_read_i[grant_id_q];
    assign w_rd_block  = w_fifo_full & ~w_pop;
    assign w_push_data = '{id: grant_id_q, burstcount: m_burstcount_i[grant_id_q]};

    always_comb begin
        state_d          = state_q;
        grant_id_d       = grant_id_q;
        wr_cnt_d         = wr_cnt_q;
        w_push           = 1'b0;
        m_waitrequest_o  = 2'b11;
        mem_address_o    = '0;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_writedata_o  = '0;
        mem_burstcount_o = '0;
        mem_byteenable_o = '0;

        case (state_q)
            IDLE: begin
                if (|w_req) begin
                    grant_id_d = w_winner;
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                mem_address_o    = m_address_i[grant_id_q];
                mem_writedata_o  = m_writedata_i[grant_id_q];
                mem_burstcount_o = m_burstcount_i[grant_id_q];
                mem_byteenable_o = m_byteenable_i[grant_id_q];
                mem_read_o       = w_rd_req & ~w_rd_block;
                mem_write_o      = w_wr_req;
                m_waitrequest_o[grant_id_q] = mem_waitrequest_i | (w_rd_req & w_rd_block);
                if (w_rd_req && !w_rd_block && !mem_waitrequest_i) begin
                    w_push  = 1'b1;
                    state_d = IDLE;
                end else if (w_wr_req && !mem_waitrequest_i) begin
                    wr_cnt_d = eff_burst(m_burstcount_i[grant_id_q]) - c_one;
                    state_d  = (wr_cnt_d == '0) ? IDLE : WR_BURST;
                end else if (!w_rd_req && !w_wr_req) begin
                    state_d = IDLE;
                end
            end

            WR_BURST: begin
                // Grant stays locked even if the master pauses its write strobe.
                mem_address_o    = m_address_i[grant_id_q];
                mem_writedata_o  = m_writedata_i[grant_id_q];
                mem_burstcount_o = m_burstcount_i[grant_id_q];
                mem_byteenable_o = m_byteenable_i[grant_id_q];
                mem_write_o      = m_write_i[grant_id_q];
                m_waitrequest_o[grant_id_q] = mem_waitrequest_i;
                if (m_write_i[grant_id_q] && !mem_waitrequest_i) begin
                    wr_cnt_d = wr_cnt_q - c_one;
                    if (wr_cnt_q == c_one) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w_beat         = mem_readdatavalid_i & ~w_fifo_empty;
    assign w_rd_remaining = (rd_cnt_q == '0) ? eff_burst(w_head.burstcount) : rd_cnt_q;
    assign w_pop          = w_beat & (w_rd_remaining == c_one);

    always_comb begin
        rd_cnt_d          = rd_cnt_q;
        m_readdatavalid_o = 2'b00;
        rsp_err_d         = rsp_err_q | (mem_readdatavalid_i & w_fifo_empty);
        if (w_beat) begin
            rd_cnt_d                  = w_rd_remaining - c_one;
            m_readdatavalid_o[w_head.id] = 1'b1;
        end
    end

    assign m_readdata_o = mem_readdata_i;
    assign rsp_err_o    = rsp_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            grant_id_q <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    arb_order_fifo #(
        .DEPTH (RD_FIFO_DEPTH)
    ) u_order_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Scoreboard bench for mem_port_arbiter (either arbitration build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import rtl_settings_pkg::*;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [AMM_ADDR_W-1:0]  addr;
        logic [AMM_DATA_W-1:0]  data;
        logic [AMM_BURST_W-1:0] bc;
        logic [DATA_B_W-1:0]    be;
    } cmd_t;

    typedef struct packed {
        logic [1:0]            mask;
        logic [AMM_DATA_W-1:0] data;
    } beat_t;

    logic                        clk = 1'b0;
    logic                        rst_n_i;
    logic [1:0]                  m_read_i;
    logic [1:0]                  m_write_i;
    logic [1:0][AMM_ADDR_W-1:0]  m_address_i;
    logic [1:0][AMM_DATA_W-1:0]  m_writedata_i;
    logic [1:0][AMM_BURST_W-1:0] m_burstcount_i;
    logic [1:0][DATA_B_W-1:0]    m_byteenable_i;
    logic [1:0]                  m_waitrequest_o;
    logic [1:0]                  m_readdatavalid_o;
    logic [AMM_DATA_W-1:0]       m_readdata_o;
    logic [AMM_ADDR_W-1:0]       mem_address_o;
    logic                        mem_read_o;
    logic                        mem_write_o;
    logic [AMM_DATA_W-1:0]       mem_writedata_o;
    logic [AMM_BURST_W-1:0]      mem_burstcount_o;
    logic [DATA_B_W-1:0]         mem_byteenable_o;
    logic                        mem_waitrequest_i;
    logic                        mem_readdatavalid_i;
    logic [AMM_DATA_W-1:0]       mem_readdata_i;
    logic                        rsp_err_o;

    cmd_t  exp_cmd  [$];
    beat_t exp_beat [$];
    cmd_t  mon_cmd_e, mon_cmd_a;
    beat_t mon_beat_e, mon_beat_a;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .RD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n_i),
        .m_read_i            (m_read_i),
        .m_write_i           (m_write_i),
        .m_address_i         (m_address_i),
        .m_writedata_i       (m_writedata_i),
        .m_burstcount_i      (m_burstcount_i),
        .m_byteenable_i      (m_byteenable_i),
        .m_waitrequest_o     (m_waitrequest_o),
        .m_readdatavalid_o   (m_readdatavalid_o),
        .m_readdata_o        (m_readdata_o),
        .mem_address_o       (mem_address_o),
        .mem_read_o          (mem_read_o),
        .mem_write_o         (mem_write_o),
        .mem_writedata_o     (mem_writedata_o),
        .mem_burstcount_o    (mem_burstcount_o),
        .mem_byteenable_o    (mem_byteenable_o),
        .mem_waitrequest_i   (mem_waitrequest_i),
        .mem_readdatavalid_i (mem_readdatavalid_i),
        .mem_readdata_i      (mem_readdata_i),
        .rsp_err_o           (rsp_err_o)
    );

    // Monitor: every accepted memory command and every returned beat is checked
    // against the next expected entry, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n_i && (mem_read_o || mem_write_o) && !mem_waitrequest_i) begin
            checks++;
            mon_cmd_a = '{rd: mem_read_o, wr: mem_write_o, addr: mem_address_o,
                          data: (mem_write_o ? mem_writedata_o : '0),
                          bc: mem_burstcount_o, be: mem_byteenable_o};
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected got rd=%0b wr=%0b addr=%h", mem_read_o, mem_write_o, mem_address_o);
            end else begin
                mon_cmd_e = exp_cmd.pop_front();
                if (mon_cmd_a !== mon_cmd_e) begin
                    errors++;
                    $display("FAIL cmd got rd=%0b wr=%0b addr=%h data=%h bc=%0d be=%h exp rd=%0b wr=%0b addr=%h data=%h bc=%0d be=%h",
                             mon_cmd_a.rd, mon_cmd_a.wr, mon_cmd_a.addr, mon_cmd_a.data, mon_cmd_a.bc, mon_cmd_a.be,
                             mon_cmd_e.rd, mon_cmd_e.wr, mon_cmd_e.addr, mon_cmd_e.data, mon_cmd_e.bc, mon_cmd_e.be);
                end
            end
        end
        if (m_readdatavalid_o != 2'b00) begin
            checks++;
            mon_beat_a = '{mask: m_readdatavalid_o, data: m_readdata_o};
            if (exp_beat.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got rdv=%b data=%h", m_readdatavalid_o, m_readdata_o);
            end else begin
                mon_beat_e = exp_beat.pop_front();
                if (mon_beat_a !== mon_beat_e) begin
                    errors++;
                    $display("FAIL beat got rdv=%b data=%h exp rdv=%b data=%h",
                             mon_beat_a.mask, mon_beat_a.data, mon_beat_e.mask, mon_beat_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rd, input logic [AMM_ADDR_W-1:0] addr,
                            input logic [AMM_DATA_W-1:0] data, input logic [AMM_BURST_W-1:0] bc);
        cmd_t c;
        c = '{rd: rd, wr: ~rd, addr: addr, data: (rd ? '0 : data), bc: bc, be: {DATA_B_W{1'b1}}};
        exp_cmd.push_back(c);
    endtask

    task automatic set_read(input int m, input logic [AMM_ADDR_W-1:0] addr, input logic [AMM_BURST_W-1:0] bc);
        m_read_i[m]       = 1'b1;
        m_address_i[m]    = addr;
        m_burstcount_i[m] = bc;
        m_byteenable_i[m] = {DATA_B_W{1'b1}};
    endtask

    // From IDLE with memory ready: grant one cycle, acceptance the next.
    task automatic issue_read(input int m, input logic [AMM_ADDR_W-1:0] addr, input logic [AMM_BURST_W-1:0] bc);
        set_read(m, addr, bc);
        push_cmd(1'b1, addr, '0, bc);
        tick();
        chk("rd_granted", {63'd0, mem_read_o}, 64'd1);
        tick();
        m_read_i[m] = 1'b0;
    endtask

    task automatic return_beat(input logic [1:0] mask, input logic [AMM_DATA_W-1:0] data);
        beat_t b;
        b = '{mask: mask, data: data};
        exp_beat.push_back(b);
        mem_readdatavalid_i = 1'b1;
        mem_readdata_i      = data;
        tick();
        mem_readdatavalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i             = 1'b1;
        m_read_i            = '0;
        m_write_i           = '0;
        m_address_i         = '0;
        m_writedata_i       = '0;
        m_burstcount_i      = '0;
        m_byteenable_i      = '0;
        mem_waitrequest_i   = 1'b0;
        mem_readdatavalid_i = 1'b0;
        mem_readdata_i      = '0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_waitreq", {62'd0, m_waitrequest_o}, 64'h3);
        chk("rst_cmd", {62'd0, mem_read_o, mem_write_o}, 64'h0);
        chk("rst_addr", {38'd0, mem_address_o}, 64'h0);
        chk("rst_rdv_err", {61'd0, m_readdatavalid_o, rsp_err_o}, 64'h0);
        tick();
        tick();
        rst_n_i = 1'b1;

        // Write burst of 4 from M0 with a stall on beat 2, while M1 wants a read.
        m_write_i[0]      = 1'b1;
        m_address_i[0]    = 26'h100;
        m_writedata_i[0]  = 32'hD000_0000;
        m_burstcount_i[0] = 4'd4;
        m_byteenable_i[0] = 4'hF;
        set_read(1, 26'h200, 4'd1);
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 26'h100, 32'hD000_0000 + i, 4'd4);
        push_cmd(1'b1, 26'h200, '0, 4'd1);
        tick();
        chk("wr_first_grant", {62'd0, m_waitrequest_o}, 64'h2);
        tick();
        m_writedata_i[0]  = 32'hD000_0001;
        mem_waitrequest_i = 1'b1;
        #1;
        chk("wr_stall_waitreq", {62'd0, m_waitrequest_o}, 64'h3);
        tick();
        mem_waitrequest_i = 1'b0;
        #1;
        chk("wr_loser_held_a", {63'd0, m_waitrequest_o[1]}, 64'd1);
        tick();
        m_writedata_i[0] = 32'hD000_0002;
        chk("wr_loser_held_b", {63'd0, m_waitrequest_o[1]}, 64'd1);
        tick();
        m_writedata_i[0] = 32'hD000_0003;
        tick();
        m_write_i[0] = 1'b0;
        chk("bubble_idle", {61'd0, mem_read_o, mem_write_o, m_waitrequest_o[1]}, 64'h1);
        tick();
        chk("m1_read_m2", {37'd0, mem_read_o, mem_address_o}, {37'd0, 1'b1, 26'h200});
        chk("m1_waitreq", {62'd0, m_waitrequest_o}, 64'h1);
        tick();
        m_read_i[1] = 1'b0;
        return_beat(2'b10, 32'hA5A5_0001);

        // Both masters request single reads continuously.
        set_read(0, 26'h010, 4'd1);
        set_read(1, 26'h020, 4'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) push_cmd(1'b1, (i % 2 == 0) ? 26'h010 : 26'h020, '0, 4'd1);
`else
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 26'h010, '0, 4'd1);
`endif
        for (int i = 0; i < 8; i++) tick();
        m_read_i = 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) return_beat((i % 2 == 0) ? 2'b01 : 2'b10, 32'hB000_0000 + i);
`else
        for (int i = 0; i < 4; i++) return_beat(2'b01, 32'hB000_0000 + i);
`endif

        // In-order routing: M0 burst of 2 then M1 burst of 3.
        issue_read(0, 26'h400, 4'd2);
        issue_read(1, 26'h500, 4'd3);
        return_beat(2'b01, 32'hC000_0000);
        return_beat(2'b01, 32'hC000_0001);
        return_beat(2'b10, 32'hC000_0002);
        return_beat(2'b10, 32'hC000_0003);
        return_beat(2'b10, 32'hC000_0004);

        // Fill the order FIFO, then release the held read with a returning beat.
        for (int i = 0; i < DEPTH; i++) issue_read(0, 26'h800 + i, 4'd1);
        set_read(0, 26'h900, 4'd1);
        tick();
        chk("full_held_a", {62'd0, mem_read_o, m_waitrequest_o[0]}, 64'h1);
        tick();
        chk("full_held_b", {62'd0, mem_read_o, m_waitrequest_o[0]}, 64'h1);
        push_cmd(1'b1, 26'h900, '0, 4'd1);
        exp_beat.push_back('{mask: 2'b01, data: 32'hE000_0000});
        mem_readdatavalid_i = 1'b1;
        mem_readdata_i      = 32'hE000_0000;
        #1;
        chk("full_release", {62'd0, mem_read_o, m_waitrequest_o[0]}, 64'h2);
        tick();
        mem_readdatavalid_i = 1'b0;
        m_read_i[0]         = 1'b0;
        for (int i = 1; i <= DEPTH; i++) return_beat(2'b01, 32'hE000_0000 + i);

        // Burstcount 0 tracks as one beat; a further beat is spurious.
        issue_read(0, 26'h600, 4'd0);
        return_beat(2'b01, 32'hF000_0000);
        chk("err_clear", {63'd0, rsp_err_o}, 64'd0);
        mem_readdatavalid_i = 1'b1;
        mem_readdata_i      = 32'hF000_0001;
        #1;
        chk("spurious_rdv", {62'd0, m_readdatavalid_o}, 64'd0);
        tick();
        mem_readdatavalid_i = 1'b0;
        chk("err_set", {63'd0, rsp_err_o}, 64'd1);
        tick();
        tick();
        chk("err_sticky", {63'd0, rsp_err_o}, 64'd1);

        // Reset mid write burst with an M0 read still outstanding.
        issue_read(0, 26'h680, 4'd2);
        m_write_i[0]      = 1'b1;
        m_address_i[0]    = 26'h300;
        m_writedata_i[0]  = 32'h1111_0000;
        m_burstcount_i[0] = 4'd8;
        push_cmd(1'b0, 26'h300, 32'h1111_0000, 4'd8);
        tick();
        tick();
        m_writedata_i[0] = 32'h1111_0001;
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_mid_cmd", {62'd0, mem_read_o, mem_write_o}, 64'h0);
        chk("rst_mid_waitreq", {62'd0, m_waitrequest_o}, 64'h3);
        chk("rst_mid_out", {33'd0, rsp_err_o, mem_address_o, mem_burstcount_o}, 64'h0);
        m_write_i[0] = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        issue_read(1, 26'h700, 4'd1);
        return_beat(2'b10, 32'h2222_0000);
        tick();

        chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        chk("beat_queue_drained", 64'(exp_beat.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master Avalon-MM arbiter that shares the single external memory port between the memory checker's transmitter (master 0) and a second requester such as a host debug/preload path (master 1). It grants whole commands (complete write bursts, single-cycle read-burst commands), tracks outstanding read bursts in order, and routes returning read beats to their owner. It sits between the masters and the memory controller, in the memory clock domain.

## Interface
- RD_FIFO_DEPTH, 8, maximum outstanding read bursts (power of two, ≥2)
- clk_i  in  1  memory clock; all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- m_read_i  in  [1:0]  per-master read request
- m_write_i  in  [1:0]  per-master write request
- m_address_i  in  [1:0][AMM_ADDR_W-1:0]  per-master address
- m_writedata_i  in  [1:0][AMM_DATA_W-1:0]  per-master write data
- m_burstcount_i  in  [1:0][AMM_BURST_W-1:0]  per-master burst length
- m_byteenable_i  in  [1:0][DATA_B_W-1:0]  per-master byte enables
- m_waitrequest_o  out  [1:0]  per-master waitrequest
- m_readdatavalid_o  out  [1:0]  per-master read beat strobe
- m_readdata_o  out  AMM_DATA_W  read data, broadcast to both masters
- mem_address_o, mem_read_o, mem_write_o, mem_writedata_o, mem_burstcount_o, mem_byteenable_o  out  package widths  memory-side command
- mem_waitrequest_i, mem_readdatavalid_i, mem_readdata_i  in  package widths  memory-side response
- rsp_err_o  out  1  sticky: a read beat arrived with no outstanding burst

## Operation
- FSM states: IDLE, GRANT, WR_BURST.
- IDLE: both m_waitrequest_o=1, mem_read_o=mem_write_o=0. If any master requests, register the winner into grant_id and go to GRANT.
- GRANT: the winner's command passes combinationally to the mem_* outputs. The winner's m_waitrequest_o = mem_waitrequest_i, forced to 1 for a read while the order FIFO is full. The loser's m_waitrequest_o = 1.
- Read accepted (mem_read_o & ~mem_waitrequest_i): push {grant_id, burstcount} to the order FIFO; return to IDLE.
- Write beat accepted: load the beat counter with burstcount-1. If that value is 0, return to IDLE; otherwise go to WR_BURST.
- WR_BURST: the grant is locked. Decrement the counter on each accepted beat; return to IDLE after the last beat. A master that deasserts write mid-burst keeps the grant; mem_write_o follows the master's write signal.
- burstcount 0 is treated as 1, both for write beats and for read tracking.
- Read return: on mem_readdatavalid_i, assert m_readdatavalid_o[head.id] in the same cycle. A read-beat counter (loaded from head.burstcount) decrements; pop the FIFO on the last beat.
- Beat with FIFO empty: drop it, set rsp_err_o; it stays set until reset.
- Simultaneous FIFO push and pop in one cycle is legal, including when the FIFO is full.
- Arbitration: see Configuration.
- Reset (any time, including mid-burst): FSM to IDLE, FIFO flushed, counters 0, rsp_err_o=0, mem_read_o=mem_write_o=0, all m_waitrequest_o=1, m_readdatavalid_o=0. Other mem_* outputs are 0 while idle.

## Timing
- Arbitration bubble: a request sampled in IDLE at cycle N appears on mem_* at N+1.
- After a command completes at cycle M, the earliest next grant is on mem_* at M+2.
- Read data path: zero latency, purely combinational from mem_readdata_i / mem_readdatavalid_i.
- Outstanding reads are limited to RD_FIFO_DEPTH bursts. Beats always return in issue order, regardless of owner.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin. A last_grant register (reset 1) gives priority to the master not granted last.
- Undefined: fixed priority; master 0 always wins a simultaneous request; the last_grant register is not built.

## Structure
- rtl_settings_pkg holds:
  - existing AMM_ADDR_W, AMM_DATA_W, AMM_BURST_W, DATA_B_W;
  - new arb_state_t enum;
  - new rd_order_t struct {id, burstcount}.
- One sub-module, arb_order_fifo: synchronous FIFO of rd_order_t, depth RD_FIFO_DEPTH, with full/empty flags, show-ahead head, and async active-low reset.

## Test plan
- M0 write burst of 4, with mem_waitrequest_i high on beat 2, while M1 requests a read → M1 stays waitrequest=1 until all 4 beats are accepted; M1's read appears on mem_* 2 cycles after the last beat.
- Both masters request reads every cycle with MEM_ARB_ROUND_ROBIN_EN → grants alternate 0,1,0,1. Without the macro → only M0 is granted while it keeps requesting.
- M0 read burst of 2, then M1 read burst of 3; memory returns 5 beats → m_readdatavalid_o pattern 01,01,10,10,10 (bit0=M0).
- Issue RD_FIFO_DEPTH reads with no data returned → the next read is held (waitrequest=1). One returned burst pops the FIFO, and the held read is accepted in the same cycle.
- mem_readdatavalid_i pulse with no outstanding read → no m_readdatavalid_o; rsp_err_o=1 until reset.
- Assert rst_n_i mid-write burst (beat 2 of 8) → all outputs at reset values immediately; after release, a fresh M1 read is granted normally.
